// File: rtl/lif_arb_pkg.sv
// Shared types and defaults for the LIF spike arbiter: event record layout and
// address-width helper.
package lif_arb_pkg;

  localparam int unsigned DefNNeurons  = 3;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefTsW       = 8;

  // Address width for n neurons; a single neuron still needs one address bit.
  function automatic int unsigned calc_aw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DefAw = calc_aw(DefNNeurons);

  typedef struct packed {
    logic [DefAw-1:0]  addr;
    logic [DefTsW-1:0] ts;
  } lif_event_t;

endpackage

// File: rtl/lif_event_fifo.sv
// Synchronous event FIFO with registered storage; the head entry is read straight
// from the storage flops, so it is stable until popped.
module lif_event_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FullCnt);
  assign o_data  = r_mem[r_rd_ptr];

  assign w_pop  = i_pop && !o_empty;
  // A pop frees the slot the push needs, so push+pop is legal even when full.
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lif_spike_arbiter.sv
// Latches spikes from N LIF neurons, grants them round-robin and serialises them as
// AER events {address, timestamp} through a small FIFO onto a valid/ready stream.
module lif_spike_arbiter
  import lif_arb_pkg::*;
#(
  parameter int unsigned N_NEURONS  = DefNNeurons,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth,
  parameter int unsigned TS_W       = DefTsW,
  localparam int unsigned AW        = calc_aw(N_NEURONS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_ena,
  input  logic                 i_tick,
  input  logic [N_NEURONS-1:0] i_spike_in,
  input  logic                 i_clr_flags,
  output logic                 o_ev_valid,
  input  logic                 i_ev_ready,
  output logic [AW-1:0]        o_ev_addr,
  output logic [TS_W-1:0]      o_ev_ts,
  output logic [N_NEURONS-1:0] o_pending,
  output logic                 o_overflow,
  output logic [7:0]           o_drop_cnt
);

  logic [N_NEURONS-1:0] r_pending;
  logic [AW-1:0]        r_rr_ptr;
  logic [TS_W-1:0]      r_ts;
  logic                 r_overflow;
  logic [7:0]           r_drop_cnt;

  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_grant;
  logic                 w_found;
  logic [AW-1:0]        w_winner;
  logic [AW-1:0]        w_rr_next;
  logic [N_NEURONS-1:0] w_pending_d;
  logic [7:0]           w_coal_cnt;
  logic [8:0]           w_drop_sum;
  logic [AW+TS_W-1:0]   w_head;

  assign w_pop   = o_ev_valid && i_ev_ready;
  assign w_grant = (|r_pending) && (!w_full || w_pop);

  // Round-robin: first pending index at or above the pointer, else lowest pending.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (!w_found && r_pending[i] && (AW'(i) >= r_rr_ptr)) begin
        w_winner = AW'(i);
        w_found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (!w_found && r_pending[i]) begin
        w_winner = AW'(i);
        w_found  = 1'b1;
      end
    end
  end

  assign w_rr_next = (w_winner == AW'(N_NEURONS - 1)) ? '0 : w_winner + AW'(1);

  // Capture is applied after the grant clear, so a spike on the winner re-arms it.
  always_comb begin
    w_pending_d = r_pending;
    w_coal_cnt  = '0;
    if (w_grant) begin
      w_pending_d[w_winner] = 1'b0;
    end
    for (int unsigned i = 0; i < N_NEURONS; i++) begin
      if (i_ena && i_spike_in[i] && r_pending[i] && !(w_grant && (w_winner == AW'(i)))) begin
        w_coal_cnt = w_coal_cnt + 8'(1);
      end
    end
    if (i_ena) begin
      w_pending_d = w_pending_d | i_spike_in;
    end
  end

  assign w_drop_sum = {1'b0, r_drop_cnt} + {1'b0, w_coal_cnt};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= '0;
      r_rr_ptr   <= '0;
      r_ts       <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pending <= w_pending_d;
      if (w_grant) begin
        r_rr_ptr <= w_rr_next;
      end
      if (i_tick && i_ena) begin
        r_ts <= r_ts + TS_W'(1);
      end
      if (i_clr_flags) begin
        r_overflow <= 1'b0;
        r_drop_cnt <= '0;
      end else if (w_coal_cnt != '0) begin
        r_overflow <= 1'b1;
        r_drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
      end
    end
  end

  lif_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AW + TS_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_grant),
    .i_data  ({w_winner, r_ts}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign o_ev_valid = !w_empty;
  assign o_ev_addr  = w_head[TS_W +: AW];
  assign o_ev_ts    = w_head[TS_W-1:0];
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;

endmodule
